// File: rtl/stopwatch_core.sv
// Stopwatch core: a 0.1 s prescaler drives an M:SS.T digit chain, with a run/pause/idle FSM
// and a split (lap) register that can freeze the display while counting carries on.
module stopwatch_core #(
    parameter int CLK_PER_TICK = 10000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       split,
    output logic [3:0] disp_d0,
    output logic [3:0] disp_d1,
    output logic [3:0] disp_d2,
    output logic [3:0] disp_d3,
    output logic       running,
    output logic       split_active,
    output logic       wrap,
    output logic [1:0] fsm_state
);

    localparam int PW = $clog2(CLK_PER_TICK);
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_TICK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [15:0]   live, live_nx;
    logic [15:0]   split_q, split_nx;
    logic [15:0]   inc;
    logic          sa_nx, wrap_nx, step;
    logic          c0, c1, c2, c3;

    assign fsm_state = state;

    // Increment of the live digits; an out-of-range digit counts as full so it rolls and carries.
    always_comb begin
        c0     = live[3:0] >= 4'd9;
        c1     = c0 && (live[7:4] >= 4'd9);
        c2     = c1 && (live[11:8] >= 4'd5);
        c3     = c2 && (live[15:12] >= 4'd9);
        inc    = live;
        inc[3:0] = c0 ? 4'd0 : live[3:0] + 4'd1;
        if (c0) inc[7:4]   = c1 ? 4'd0 : live[7:4] + 4'd1;
        if (c1) inc[11:8]  = c2 ? 4'd0 : live[11:8] + 4'd1;
        if (c2) inc[15:12] = c3 ? 4'd0 : live[15:12] + 4'd1;
    end

    always_comb begin
        step     = (state == RUN) && (presc == LAST);
        state_nx = state;
        presc_nx = presc;
        live_nx  = live;
        split_nx = split_q;
        sa_nx    = split_active;
        wrap_nx  = 1'b0;
        case (state)
            IDLE: begin
                presc_nx = '0;
                if (clear) begin
                    live_nx  = '0;
                    split_nx = '0;
                    sa_nx    = 1'b0;
                end else if (start_stop) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (step) begin
                    presc_nx = '0;
                    live_nx  = inc;
                    wrap_nx  = c3;
                end else begin
                    presc_nx = presc + PW'(1);
                end
                if (start_stop) state_nx = PAUSE;
                // Split latches the value being written this edge, so a coincident step is included.
                if (split) begin
                    if (!split_active) begin
                        split_nx = live_nx;
                        sa_nx    = 1'b1;
                    end else begin
                        sa_nx    = 1'b0;
                    end
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_nx = IDLE;
                    presc_nx = '0;
                    live_nx  = '0;
                    split_nx = '0;
                    sa_nx    = 1'b0;
                end else if (start_stop) begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
                presc_nx = '0;
                live_nx  = '0;
                split_nx = '0;
                sa_nx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            presc        <= '0;
            live         <= '0;
            split_q      <= '0;
            split_active <= 1'b0;
            wrap         <= 1'b0;
            running      <= 1'b0;
            disp_d0      <= 4'd0;
            disp_d1      <= 4'd0;
            disp_d2      <= 4'd0;
            disp_d3      <= 4'd0;
        end else begin
            state        <= state_nx;
            presc        <= presc_nx;
            live         <= live_nx;
            split_q      <= split_nx;
            split_active <= sa_nx;
            wrap         <= wrap_nx;
            running      <= (state_nx == RUN);
            {disp_d3, disp_d2, disp_d1, disp_d0} <= sa_nx ? split_nx : live_nx;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at CLK_PER_TICK=4 (one count step every 4 RUN cycles).
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset_n, start_stop, clear, split;
    logic [3:0] disp_d0, disp_d1, disp_d2, disp_d3;
    logic       running, split_active, wrap;
    logic [1:0] fsm_state;
    int         tests = 0;
    int         fails = 0;

    stopwatch_core #(.CLK_PER_TICK(4)) dut (
        .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear), .split(split),
        .disp_d0(disp_d0), .disp_d1(disp_d1), .disp_d2(disp_d2), .disp_d3(disp_d3),
        .running(running), .split_active(split_active), .wrap(wrap), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic ss, input logic cl, input logic sp);
        start_stop = ss; clear = cl; split = sp;
        tick(1);
        start_stop = 1'b0; clear = 1'b0; split = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] disp();
        return {disp_d3, disp_d2, disp_d1, disp_d0};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; start_stop = 1'b0; clear = 1'b0; split = 1'b0;

        do_reset();
        chk("reset_disp", disp(), 16'h0000);
        chk("reset_running", running, 1'b0);
        chk("reset_split", split_active, 1'b0);
        chk("reset_wrap", wrap, 1'b0);
        chk("reset_state", fsm_state, 2'd0);

        // 40 RUN cycles = 10 steps = 0:01.0
        pulse(1, 0, 0);
        chk("run_running", running, 1'b1);
        tick(40);
        chk("run40_disp", disp(), 16'h0010);
        chk("run40_running", running, 1'b1);

        // Pause mid-prescaler and resume: remaining count is kept
        do_reset();
        pulse(1, 0, 0);
        tick(14);
        chk("pre_pause_disp", disp(), 16'h0003);
        pulse(1, 0, 0);
        chk("paused_running", running, 1'b0);
        tick(20);
        chk("paused_disp", disp(), 16'h0003);
        pulse(1, 0, 0);
        chk("resume_disp", disp(), 16'h0003);
        chk("resume_running", running, 1'b1);
        tick(1);
        chk("resume_step", disp(), 16'h0004);
        tick(3);
        chk("resume_nodup", disp(), 16'h0004);
        tick(1);
        chk("resume_next", disp(), 16'h0005);

        // Split freezes the display while counting continues
        do_reset();
        pulse(1, 0, 0);
        tick(100);
        chk("split_pre", disp(), 16'h0025);
        pulse(0, 0, 1);
        chk("split_active_set", split_active, 1'b1);
        tick(8);
        chk("split_frozen", disp(), 16'h0025);
        chk("split_still_active", split_active, 1'b1);
        pulse(0, 0, 1);
        chk("split_release", disp(), 16'h0027);
        chk("split_active_clr", split_active, 1'b0);

        // clear ignored in RUN; start_stop on a step edge still applies the step
        pulse(0, 1, 0);
        chk("clear_in_run_state", fsm_state, 2'd1);
        chk("clear_in_run_disp", disp(), 16'h0027);
        pulse(1, 0, 0);
        chk("step_and_stop_disp", disp(), 16'h0028);
        chk("step_and_stop_state", fsm_state, 2'd2);
        pulse(0, 0, 1);
        chk("split_ignored_pause", split_active, 1'b0);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        chk("split_in_run2", split_active, 1'b1);
        pulse(1, 0, 0);
        chk("split_persists_pause", split_active, 1'b1);
        chk("split_pause_disp", disp(), 16'h0028);
        pulse(1, 1, 0);
        chk("ss_clear_state", fsm_state, 2'd0);
        chk("ss_clear_disp", disp(), 16'h0000);
        chk("ss_clear_split", split_active, 1'b0);
        chk("ss_clear_running", running, 1'b0);
        pulse(1, 1, 0);
        chk("idle_ss_clear", fsm_state, 2'd0);

        // Roll-over from 9:59.9
        do_reset();
        pulse(1, 0, 0);
        tick(23996);
        chk("wrap_pre_disp", disp(), 16'h9599);
        tick(3);
        chk("wrap_pre_pulse", wrap, 1'b0);
        tick(1);
        chk("wrap_disp", disp(), 16'h0000);
        chk("wrap_pulse", wrap, 1'b1);
        chk("wrap_running", running, 1'b1);
        tick(1);
        chk("wrap_once", wrap, 1'b0);
        tick(3);
        chk("wrap_keeps_counting", disp(), 16'h0001);

        // Reset mid-RUN at 3:17.4
        do_reset();
        pulse(1, 0, 0);
        tick(7896);
        chk("mid_pre_disp", disp(), 16'h3174);
        tick(2);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk("mid_rst_disp", disp(), 16'h0000);
        chk("mid_rst_running", running, 1'b0);
        chk("mid_rst_state", fsm_state, 2'd0);
        chk("mid_rst_split", split_active, 1'b0);
        tick(8);
        chk("mid_rst_stays_idle", disp(), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
